// File: rtl/rvfi_pkg.sv
// rvfi_pkg
//   Shared types and constants for the RVFI commit tracker.
//   rvfi_rec_t carries every field the rvfi_itf monitor consumes for one
//   retired instruction.
package rvfi_pkg;

   localparam int XLEN   = 32;
   localparam int REG_AW = 5;

   typedef struct packed {
      logic [XLEN-1:0]   inst;
      logic              trap;
      logic [REG_AW-1:0] rs1_addr;
      logic [REG_AW-1:0] rs2_addr;
      logic [XLEN-1:0]   rs1_rdata;
      logic [XLEN-1:0]   rs2_rdata;
      logic              load_regfile;
      logic [REG_AW-1:0] rd_addr;
      logic [XLEN-1:0]   rd_wdata;
      logic [XLEN-1:0]   pc_rdata;
      logic [XLEN-1:0]   pc_wdata;
      logic [XLEN-1:0]   mem_addr;
      logic [3:0]        mem_rmask;
      logic [3:0]        mem_wmask;
      logic [XLEN-1:0]   mem_rdata;
      logic [XLEN-1:0]   mem_wdata;
   } rvfi_rec_t;

endpackage

// File: rtl/rvfi_watchdog.sv
// rvfi_watchdog
//   Saturating idle counter with a sticky timeout flag. The count clears on
//   every commit and otherwise increments; timeout_o latches once the count
//   reaches CYCLES and holds until reset.
// Ports:
//   clk       - clock, rising edge
//   rst       - asynchronous active-low reset
//   commit_i  - registered commit pulse from the tracker
//   timeout_o - sticky no-commit timeout flag
module rvfi_watchdog #(
   parameter int CYCLES = 10000
) (
   input  logic clk,
   input  logic rst,
   input  logic commit_i,
   output logic timeout_o
);

   localparam int CW = $clog2(CYCLES + 1);

   logic [CW-1:0] cnt_q, cnt_d;
   logic          timeout_q, timeout_d;

   always_comb begin
      cnt_d     = cnt_q;
      timeout_d = timeout_q;
      if (commit_i) begin
         cnt_d = '0;
      end else if (cnt_q != CW'(CYCLES)) begin
         cnt_d = cnt_q + 1'b1;
      end
      if (cnt_d == CW'(CYCLES)) begin
         timeout_d = 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         cnt_q     <= '0;
         timeout_q <= 1'b0;
      end else begin
         cnt_q     <= cnt_d;
         timeout_q <= timeout_d;
      end
   end

   assign timeout_o = timeout_q;

endmodule

// File: rtl/rvfi_commit_tracker.sv
// rvfi_commit_tracker
//   Carries one RVFI record per in-flight instruction in a slot array that
//   shifts with the pipeline, merges execute/memory annotations into the
//   record at EX_STAGE/MEM_STAGE, and emits one registered commit per retired
//   instruction together with order, halt and (optionally) watchdog flags.
//   Optional feature: define RVFI_WATCHDOG_EN to build the rvfi_watchdog
//   idle counter; otherwise wdog_timeout is tied to 0.
// Ports:
//   clk, rst                     - clock (rising), async active-low reset
//   advance, flush               - pipeline advance (not stalled), squash
//   ins_*                        - instruction entering slot 0
//   ex_*                         - execute annotation at EX_STAGE
//   mem_*                        - memory annotation at MEM_STAGE
//   wb_*                         - writeback values sampled at retire
//   commit, order, rec           - registered commit pulse, index, record
//   halt, wdog_timeout           - sticky loop flag, sticky idle timeout
//
// Handshake: there is no back-pressure. A record moves one slot on every edge
// where advance=1; commit is a single-cycle valid with no ready, asserted in
// the cycle after the edge that retired slot STAGES-1.
module rvfi_commit_tracker
   import rvfi_pkg::*;
#(
   parameter int STAGES          = 5,
   parameter int EX_STAGE        = 2,
   parameter int MEM_STAGE       = 3,
   parameter int FLUSH_STAGES    = 2,
   parameter int ORDER_W         = 64,
   parameter int WATCHDOG_CYCLES = 10000
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               advance,
   input  logic               flush,
   input  logic               ins_valid,
   input  logic [31:0]        ins_inst,
   input  logic [31:0]        ins_pc,
   input  logic               ex_we,
   input  logic [4:0]         ex_rs1_addr,
   input  logic [4:0]         ex_rs2_addr,
   input  logic [31:0]        ex_rs1_rdata,
   input  logic [31:0]        ex_rs2_rdata,
   input  logic [31:0]        ex_pc_wdata,
   input  logic               ex_trap,
   input  logic               mem_we,
   input  logic [31:0]        mem_addr,
   input  logic [3:0]         mem_rmask,
   input  logic [3:0]         mem_wmask,
   input  logic [31:0]        mem_rdata,
   input  logic [31:0]        mem_wdata,
   input  logic               wb_load_regfile,
   input  logic [4:0]         wb_rd_addr,
   input  logic [31:0]        wb_rd_wdata,
   output logic               commit,
   output logic [ORDER_W-1:0] order,
   output rvfi_rec_t          rec,
   output logic               halt,
   output logic               wdog_timeout
);

   localparam int LAST = STAGES - 1;

   rvfi_rec_t             slot_q [STAGES];
   rvfi_rec_t             slot_d [STAGES];
   rvfi_rec_t             ann    [STAGES];
   logic [STAGES-1:0]     vld_q, vld_d;

   rvfi_rec_t             rec_q, rec_d;
   logic                  commit_q, commit_d;
   logic [ORDER_W-1:0]    order_q, order_d;
   logic                  halt_q, halt_d;
   logic                  retire;

   always_comb begin
      // Annotation is applied before the shift so a record written on an
      // advancing edge carries the new fields into index+1.
      for (int i = 0; i < STAGES; i++) begin
         ann[i] = slot_q[i];
      end
      if (ex_we && vld_q[EX_STAGE]) begin
         ann[EX_STAGE].rs1_addr  = ex_rs1_addr;
         ann[EX_STAGE].rs2_addr  = ex_rs2_addr;
         ann[EX_STAGE].rs1_rdata = ex_rs1_rdata;
         ann[EX_STAGE].rs2_rdata = ex_rs2_rdata;
         ann[EX_STAGE].pc_wdata  = ex_pc_wdata;
         ann[EX_STAGE].trap      = ex_trap;
      end
      if (mem_we && vld_q[MEM_STAGE]) begin
         ann[MEM_STAGE].mem_addr  = mem_addr;
         ann[MEM_STAGE].mem_rmask = mem_rmask;
         ann[MEM_STAGE].mem_wmask = mem_wmask;
         ann[MEM_STAGE].mem_rdata = mem_rdata;
         ann[MEM_STAGE].mem_wdata = mem_wdata;
      end

      if (advance) begin
         slot_d[0]          = '0;
         slot_d[0].inst     = ins_inst;
         slot_d[0].pc_rdata = ins_pc;
         vld_d[0]           = ins_valid;
         for (int i = 1; i < STAGES; i++) begin
            slot_d[i] = ann[i-1];
            vld_d[i]  = vld_q[i-1];
         end
      end else begin
         for (int i = 0; i < STAGES; i++) begin
            slot_d[i] = ann[i];
         end
         vld_d = vld_q;
      end

      // Flush wins over insertion in the low slots; the record that would
      // have shifted out of the flushed region becomes a bubble.
      if (flush) begin
         for (int i = 0; i < FLUSH_STAGES; i++) begin
            vld_d[i] = 1'b0;
         end
         if (advance) begin
            vld_d[FLUSH_STAGES] = 1'b0;
         end
      end
   end

   assign retire = advance & vld_q[LAST];

   always_comb begin
      rec_d    = rec_q;
      commit_d = retire;
      order_d  = order_q + ORDER_W'(commit_q);
      halt_d   = halt_q;
      if (retire) begin
         rec_d              = ann[LAST];
         rec_d.load_regfile = wb_load_regfile;
         rec_d.rd_addr      = wb_load_regfile ? wb_rd_addr : '0;
         rec_d.rd_wdata     = (wb_load_regfile && (wb_rd_addr != '0)) ? wb_rd_wdata : '0;
         // A self-targeting jump means the program is parked in a loop.
         if (rec_d.pc_wdata == rec_d.pc_rdata) begin
            halt_d = 1'b1;
         end
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int i = 0; i < STAGES; i++) begin
            slot_q[i] <= '0;
         end
         vld_q    <= '0;
         rec_q    <= '0;
         commit_q <= 1'b0;
         order_q  <= '0;
         halt_q   <= 1'b0;
      end else begin
         for (int i = 0; i < STAGES; i++) begin
            slot_q[i] <= slot_d[i];
         end
         vld_q    <= vld_d;
         rec_q    <= rec_d;
         commit_q <= commit_d;
         order_q  <= order_d;
         halt_q   <= halt_d;
      end
   end

   assign commit = commit_q;
   assign order  = order_q;
   assign rec    = rec_q;
   assign halt   = halt_q;

`ifdef RVFI_WATCHDOG_EN
   rvfi_watchdog #(
      .CYCLES (WATCHDOG_CYCLES)
   ) u_wdog (
      .clk       (clk),
      .rst       (rst),
      .commit_i  (commit_q),
      .timeout_o (wdog_timeout)
   );
`else
   logic unused_wdog_cycles;
   assign unused_wdog_cycles = ^WATCHDOG_CYCLES;
   assign wdog_timeout       = 1'b0;
`endif

endmodule

// File: tb/tb_rvfi_commit_tracker.sv
module tb_rvfi_commit_tracker;
   import rvfi_pkg::*;

   localparam int STAGES       = 5;
   localparam int EX_STAGE     = 2;
   localparam int MEM_STAGE    = 3;
   localparam int FLUSH_STAGES = 2;
   localparam int W            = $bits(rvfi_rec_t);

   // ---------------- clock / reset ----------------
   logic clk = 1'b0;
   logic rst = 1'b0;
   always #5 clk = ~clk;

   logic        advance, flush, ins_valid;
   logic [31:0] ins_inst, ins_pc;
   logic        ex_we, ex_trap;
   logic [4:0]  ex_rs1_addr, ex_rs2_addr;
   logic [31:0] ex_rs1_rdata, ex_rs2_rdata, ex_pc_wdata;
   logic        mem_we;
   logic [31:0] mem_addr, mem_rdata, mem_wdata;
   logic [3:0]  mem_rmask, mem_wmask;
   logic        wb_load_regfile;
   logic [4:0]  wb_rd_addr;
   logic [31:0] wb_rd_wdata;
   logic        commit, halt, wdog_timeout;
   logic [63:0] order;
   rvfi_rec_t   rec;

   rvfi_commit_tracker #(
      .STAGES          (STAGES),
      .EX_STAGE        (EX_STAGE),
      .MEM_STAGE       (MEM_STAGE),
      .FLUSH_STAGES    (FLUSH_STAGES),
      .ORDER_W         (64),
      .WATCHDOG_CYCLES (16)
   ) dut (
      .clk             (clk),
      .rst             (rst),
      .advance         (advance),
      .flush           (flush),
      .ins_valid       (ins_valid),
      .ins_inst        (ins_inst),
      .ins_pc          (ins_pc),
      .ex_we           (ex_we),
      .ex_rs1_addr     (ex_rs1_addr),
      .ex_rs2_addr     (ex_rs2_addr),
      .ex_rs1_rdata    (ex_rs1_rdata),
      .ex_rs2_rdata    (ex_rs2_rdata),
      .ex_pc_wdata     (ex_pc_wdata),
      .ex_trap         (ex_trap),
      .mem_we          (mem_we),
      .mem_addr        (mem_addr),
      .mem_rmask       (mem_rmask),
      .mem_wmask       (mem_wmask),
      .mem_rdata       (mem_rdata),
      .mem_wdata       (mem_wdata),
      .wb_load_regfile (wb_load_regfile),
      .wb_rd_addr      (wb_rd_addr),
      .wb_rd_wdata     (wb_rd_wdata),
      .commit          (commit),
      .order           (order),
      .rec             (rec),
      .halt            (halt),
      .wdog_timeout    (wdog_timeout)
   );

   // ---------------- scoreboard state ----------------
   logic [W-1:0] exp_q[$];
   logic [W-1:0] exp_w;
   int           n_cmp = 0;
   int           n_err = 0;
   int           edge_cnt = 0;
   int           n_commits = 0;
   rvfi_rec_t    m_rec [STAGES];
   logic         m_vld [STAGES];
   logic         exp_commit = 1'b0;
   logic         exp_halt = 1'b0;
   logic [63:0]  exp_order = '0;
   bit           mon_en = 1'b0;
   rvfi_rec_t    last_rec = '0;
   bit           lat_arm = 1'b0;
   int           lat_ins_edge = 0;
   int           lat_commit_edge = 0;

   task automatic check(input string tag, input logic [383:0] got, input logic [383:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Reference model: records move with advance, pick up annotations where
   // valid, and the retiring record gets the writeback forcing rules.
   task automatic model_step();
      rvfi_rec_t r;
      if (ex_we && m_vld[EX_STAGE]) begin
         m_rec[EX_STAGE].rs1_addr  = ex_rs1_addr;
         m_rec[EX_STAGE].rs2_addr  = ex_rs2_addr;
         m_rec[EX_STAGE].rs1_rdata = ex_rs1_rdata;
         m_rec[EX_STAGE].rs2_rdata = ex_rs2_rdata;
         m_rec[EX_STAGE].pc_wdata  = ex_pc_wdata;
         m_rec[EX_STAGE].trap      = ex_trap;
      end
      if (mem_we && m_vld[MEM_STAGE]) begin
         m_rec[MEM_STAGE].mem_addr  = mem_addr;
         m_rec[MEM_STAGE].mem_rmask = mem_rmask;
         m_rec[MEM_STAGE].mem_wmask = mem_wmask;
         m_rec[MEM_STAGE].mem_rdata = mem_rdata;
         m_rec[MEM_STAGE].mem_wdata = mem_wdata;
      end
      exp_commit = advance && m_vld[STAGES-1];
      if (exp_commit) begin
         r              = m_rec[STAGES-1];
         r.load_regfile = wb_load_regfile;
         r.rd_addr      = wb_load_regfile ? wb_rd_addr : 5'd0;
         r.rd_wdata     = (wb_load_regfile && wb_rd_addr != 5'd0) ? wb_rd_wdata : 32'd0;
         exp_q.push_back(r);
         if (r.pc_wdata == r.pc_rdata) exp_halt = 1'b1;
      end
      if (advance) begin
         for (int i = STAGES - 1; i > 0; i--) begin
            m_rec[i] = m_rec[i-1];
            m_vld[i] = m_vld[i-1];
         end
         m_rec[0]          = '0;
         m_rec[0].inst     = ins_inst;
         m_rec[0].pc_rdata = ins_pc;
         m_vld[0]          = ins_valid;
      end
      if (flush) begin
         for (int i = 0; i < FLUSH_STAGES; i++) m_vld[i] = 1'b0;
         if (advance) m_vld[FLUSH_STAGES] = 1'b0;
      end
   endtask

   // ---------------- driver tasks ----------------
   task automatic cyc();
      @(posedge clk);
      model_step();
      edge_cnt++;
      #1;
   endtask

   task automatic set_idle();
      advance = 1'b1; flush = 1'b0; ins_valid = 1'b0;
      ins_inst = 32'h0000_0013; ins_pc = 32'h0;
      ex_we = 1'b0; ex_trap = 1'b0; ex_rs1_addr = '0; ex_rs2_addr = '0;
      ex_rs1_rdata = '0; ex_rs2_rdata = '0; ex_pc_wdata = 32'h4;
      mem_we = 1'b0; mem_addr = '0; mem_rmask = '0; mem_wmask = '0;
      mem_rdata = '0; mem_wdata = '0;
      wb_load_regfile = 1'b0; wb_rd_addr = '0; wb_rd_wdata = '0;
   endtask

   task automatic idle(input int n);
      set_idle();
      for (int i = 0; i < n; i++) cyc();
   endtask

   task automatic insert(input logic [31:0] pc);
      set_idle();
      ins_valid = 1'b1;
      ins_pc    = pc;
      cyc();
   endtask

   task automatic do_reset();
      mon_en = 1'b0;
      @(negedge clk);
      rst = 1'b0;
      set_idle();
      #1;
      check("rst_commit", commit, 1'b0);
      check("rst_order", order, 64'd0);
      check("rst_rec", rec, '0);
      check("rst_halt", halt, 1'b0);
      check("rst_wdog", wdog_timeout, 1'b0);
      for (int i = 0; i < STAGES; i++) begin
         m_vld[i] = 1'b0;
         m_rec[i] = '0;
      end
      exp_q.delete();
      exp_commit = 1'b0;
      exp_halt   = 1'b0;
      exp_order  = '0;
      @(negedge clk);
      rst    = 1'b1;
      mon_en = 1'b1;
   endtask

   // Drives one instruction through to retire with the given wb values.
   task automatic retire_with(input logic [31:0] pc, input logic lr,
                              input logic [4:0] rd, input logic [31:0] wd);
      insert(pc);
      idle(STAGES - 1);
      set_idle();
      wb_load_regfile = lr;
      wb_rd_addr      = rd;
      wb_rd_wdata     = wd;
      cyc();
      idle(2);
   endtask

   // ---------------- monitor ----------------
   always @(negedge clk) begin
      if (mon_en) begin
         check("commit", commit, exp_commit);
         check("halt", halt, exp_halt);
         if (commit) begin
            n_commits++;
            if (exp_q.size() == 0) begin
               check("sb_underflow", commit, 1'b0);
            end else begin
               exp_w = exp_q.pop_front();
               check("rec", rec, exp_w);
               check("order", order, exp_order);
            end
            exp_order = exp_order + 64'd1;
            last_rec  = rec;
            if (lat_arm) begin
               lat_commit_edge = edge_cnt;
               lat_arm = 1'b0;
            end
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL timeout: simulation time limit reached");
      $fatal(1, "timeout");
   end

   // ---------------- stimulus ----------------
   initial begin
      int c0;
      set_idle();
      do_reset();

      // Three back-to-back instructions with execute annotations every cycle.
      set_idle();
      ins_valid = 1'b1; ins_pc = 32'h60; ex_we = 1'b1; ex_pc_wdata = 32'h100;
      ex_rs1_addr = 5'd3; ex_rs1_rdata = 32'h1234;
      cyc();
      lat_ins_edge = edge_cnt;
      lat_arm = 1'b1;
      ins_pc = 32'h64; cyc();
      ins_pc = 32'h68; cyc();
      ins_valid = 1'b0;
      for (int i = 0; i < 6; i++) cyc();
      idle(2);
      check("latency", lat_commit_edge - lat_ins_edge, STAGES);
      check("first3_last_pc", last_rec.pc_rdata, 32'h68);
      check("first3_order", order, 64'd3);

      // Stall with the memory stage responding over three cycles.
      insert(32'h200);
      idle(3);
      set_idle();
      advance = 1'b0; mem_we = 1'b1; mem_addr = 32'h1000; mem_rmask = 4'hf;
      c0 = n_commits;
      mem_rdata = 32'h11; cyc();
      mem_rdata = 32'h22; cyc();
      mem_rdata = 32'h33; cyc();
      check("stall_no_commit", n_commits - c0, 0);
      idle(4);
      check("stall_pc", last_rec.pc_rdata, 32'h200);
      check("stall_mem_rdata", last_rec.mem_rdata, 32'h33);

      // Flush with the two youngest slots occupied.
      c0 = n_commits;
      insert(32'h300);
      insert(32'h304);
      insert(32'h308);
      set_idle();
      flush = 1'b1; ins_valid = 1'b1; ins_pc = 32'h30c;
      cyc();
      idle(8);
      check("flush_count", n_commits - c0, 1);
      check("flush_survivor", last_rec.pc_rdata, 32'h300);

      // Writeback forcing rules.
      retire_with(32'h400, 1'b1, 5'd0, 32'hdead);
      check("rd0_wdata", last_rec.rd_wdata, 32'h0);
      retire_with(32'h404, 1'b0, 5'd7, 32'h55);
      check("nolr_rd_addr", last_rec.rd_addr, 5'd0);
      retire_with(32'h408, 1'b1, 5'd5, 32'hbeef);
      check("wb_rd_addr", last_rec.rd_addr, 5'd5);
      check("wb_rd_wdata", last_rec.rd_wdata, 32'hbeef);

      // Random traffic against the model.
      for (int n = 0; n < 300; n++) begin
         advance         = ($urandom_range(0, 3) != 0);
         flush           = ($urandom_range(0, 9) == 0);
         ins_valid       = $urandom_range(0, 1);
         ins_inst        = $urandom();
         ins_pc          = ($urandom() & 32'hffff_fffc) | 32'h4;
         ex_we           = $urandom_range(0, 1);
         ex_trap         = $urandom_range(0, 1);
         ex_rs1_addr     = $urandom_range(0, 31);
         ex_rs2_addr     = $urandom_range(0, 31);
         ex_rs1_rdata    = $urandom();
         ex_rs2_rdata    = $urandom();
         ex_pc_wdata     = $urandom();
         mem_we          = $urandom_range(0, 1);
         mem_addr        = $urandom();
         mem_rmask       = $urandom_range(0, 15);
         mem_wmask       = $urandom_range(0, 15);
         mem_rdata       = $urandom();
         mem_wdata       = $urandom();
         wb_load_regfile = $urandom_range(0, 1);
         wb_rd_addr      = ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
         wb_rd_wdata     = $urandom();
         cyc();
      end
      idle(STAGES + 3);
      check("sb_empty", exp_q.size(), 0);

      // Halt on a self-jump, then asynchronous reset mid-cycle.
      do_reset();
      set_idle();
      ins_valid = 1'b1; ins_pc = 32'h80; ins_inst = 32'h0000_006f;
      cyc();
      idle(2);
      set_idle();
      ex_we = 1'b1; ex_pc_wdata = 32'h80;
      cyc();
      idle(4);
      check("halt_set", halt, 1'b1);
      check("halt_pc", last_rec.pc_rdata, 32'h80);
      idle(3);
      check("halt_sticky", halt, 1'b1);
      mon_en = 1'b0;
      rst = 1'b0;
      #1;
      check("halt_async_clr", halt, 1'b0);
      check("order_async_clr", order, 64'd0);
      #1;
      do_reset();

      // Idle watchdog.
      set_idle();
      advance = 1'b0;
`ifdef RVFI_WATCHDOG_EN
      for (int i = 0; i < 15; i++) cyc();
      check("wdog_before", wdog_timeout, 1'b0);
      cyc();
      check("wdog_after", wdog_timeout, 1'b1);
      for (int i = 0; i < 4; i++) cyc();
      check("wdog_sticky", wdog_timeout, 1'b1);
`else
      for (int i = 0; i < 20; i++) cyc();
      check("wdog_off", wdog_timeout, 1'b0);
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
